// File: rtl/mem_split_sequencer.sv
// mem_split_sequencer: sequences one request through TLB/protection check and one or two cache line parts
module mem_split_sequencer #(
  parameter int AW = 32,
  parameter int IDW = 7,
  parameter int TO_CYC = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [AW-1:0]  req_addr,
  input  logic [1:0]     req_size,
  input  logic           req_w,
  input  logic [IDW-1:0] req_id,
  output logic [AW-1:0]  al_addr,
  output logic [1:0]     al_size,
  output logic           al_w,
  output logic           al_valid,
  input  logic           al_needP1,
  input  logic           al_tlb_hit,
  input  logic           al_tlb_miss,
  input  logic           al_prot_exc,
  output logic           cache_valid,
  output logic           cache_part,
  input  logic           cache_ack,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [1:0]     rsp_fault,
  output logic           busy
);
  localparam int CW = (TO_CYC > 2) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] TOP = CW'(TO_CYC - 1);
  typedef enum logic [2:0] {IDLE, CHECK, P0, P1, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0] size_q, size_d, fault_q, fault_d;
  logic w_q, w_d, need1_q, need1_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bad;
  assign bad = al_prot_exc | al_tlb_miss | !al_tlb_hit;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    size_d = size_q;
    w_d = w_q;
    id_d = id_q;
    need1_d = need1_q;
    fault_d = fault_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        size_d = req_size;
        w_d = req_w;
        id_d = req_id;
        need1_d = 1'b0;
        state_d = CHECK;
      end
      CHECK: begin
        need1_d = al_needP1;
        cnt_d = '0;
        fault_d = al_prot_exc ? 2'b10 : bad ? 2'b01 : 2'b00;
        state_d = bad ? RESP : P0;
      end
      P0, P1: if (cache_ack) begin
        cnt_d = '0;
        fault_d = 2'b00;
        state_d = (state_q == P0 && need1_q) ? P1 : RESP;
      end else if (cnt_q == TOP) begin
        fault_d = 2'b11;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      size_q <= '0;
      w_q <= 1'b0;
      id_q <= '0;
      need1_q <= 1'b0;
      fault_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      size_q <= size_d;
      w_q <= w_d;
      id_q <= id_d;
      need1_q <= need1_d;
      fault_q <= fault_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign al_valid = state_q == CHECK || state_q == P0 || state_q == P1;
  assign cache_valid = state_q == P0 || state_q == P1;
  assign cache_part = state_q == P1;
  assign rsp_valid = state_q == RESP;
  assign al_addr = addr_q;
  assign al_size = size_q;
  assign al_w = w_q;
  assign rsp_id = id_q;
  assign rsp_fault = fault_q;
endmodule
